// File: rtl/a2d_sequencer.sv
// a2d_sequencer: round-robin conversion sequencer in front of the SPI A2D
// interface. Averages 2^AVG_LOG2 conversions per enabled channel and keeps
// the truncated 12-bit averages in a bank with a registered read port.
module a2d_sequencer #(
    parameter int AVG_LOG2    = 2,
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  ch_mask,
    output logic        strt_cnv,
    output logic [2:0]  chnnl,
    input  logic        cnv_cmplt,
    input  logic [11:0] res,
    input  logic [2:0]  rd_ch,
    output logic [11:0] rd_data,
    output logic [7:0]  ch_valid,
    output logic        sweep_done,
    output logic        busy,
    output logic        err,
    input  logic        clr_err
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int SC_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [SC_W-1:0] SC_LAST = SC_W'((1 << AVG_LOG2) - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] SETTLE    = 3'd1;
    localparam logic [2:0] START     = 3'd2;
    localparam logic [2:0] WAIT_BUSY = 3'd3;
    localparam logic [2:0] WAIT_DONE = 3'd4;
    localparam logic [2:0] STORE     = 3'd5;

    logic [2:0]       state;
    logic [7:0]       mask_q;
    logic [2:0]       cur_ch;
    logic [7:0]       settle_cnt;
    logic             start_cnt;
    logic [9:0]       to_cnt;
    logic [ACC_W-1:0] accum;
    logic [SC_W-1:0]  sample_cnt;
    logic             abort_q;
    logic [11:0]      bank [8];
    logic [3:0]       first_ch;
    logic [3:0]       next_ch;
    logic             to_hit;

    // {found, index} of the lowest set bit of m at or above position lo
    function automatic logic [3:0] pick(input logic [7:0] m, input logic [3:0] lo);
        logic [3:0] r;
        r = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (!r[3] && m[i] && (i >= 32'(lo))) r = {1'b1, 3'(i)};
        end
        return r;
    endfunction

    // channel selection for sweep start and for advancing within a sweep
    always_comb begin
        first_ch = pick(ch_mask, 4'd0);
        next_ch  = pick(mask_q, 4'(cur_ch) + 4'd1);
        to_hit   = (to_cnt == 10'(TIMEOUT_CYC - 1));
    end

    assign strt_cnv = (state == START);
    assign busy     = (state != IDLE);

    // sequencing FSM, settle/timeout counters, accumulator and error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mask_q     <= '0;
            cur_ch     <= '0;
            chnnl      <= '0;
            settle_cnt <= '0;
            start_cnt  <= 1'b0;
            to_cnt     <= '0;
            accum      <= '0;
            sample_cnt <= '0;
            abort_q    <= 1'b0;
            sweep_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            sweep_done <= 1'b0;
            // a timeout later in this block overrides the clear
            if (clr_err) err <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && first_ch[3]) begin
                        mask_q     <= ch_mask;
                        cur_ch     <= first_ch[2:0];
                        settle_cnt <= '0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!en) begin
                        accum      <= '0;
                        sample_cnt <= '0;
                        state      <= IDLE;
                    end else if (settle_cnt == 8'(SETTLE_CYC - 1)) begin
                        chnnl     <= cur_ch;
                        start_cnt <= 1'b0;
                        state     <= START;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                START: begin
                    if (start_cnt) begin
                        to_cnt <= '0;
                        state  <= WAIT_BUSY;
                    end else begin
                        start_cnt <= 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (!cnv_cmplt) begin
                        to_cnt <= '0;
                        state  <= WAIT_DONE;
                    end else if (to_hit) begin
                        err        <= 1'b1;
                        accum      <= '0;
                        sample_cnt <= '0;
                        abort_q    <= 1'b1;
                        state      <= STORE;
                    end else begin
                        to_cnt <= to_cnt + 10'd1;
                    end
                end
                WAIT_DONE: begin
                    if (cnv_cmplt) begin
                        if (!en) begin
                            accum      <= '0;
                            sample_cnt <= '0;
                            state      <= IDLE;
                        end else begin
                            accum <= accum + ACC_W'(res);
                            if (sample_cnt == SC_LAST) begin
                                sample_cnt <= '0;
                                abort_q    <= 1'b0;
                                state      <= STORE;
                            end else begin
                                sample_cnt <= sample_cnt + 1'b1;
                                settle_cnt <= '0;
                                state      <= SETTLE;
                            end
                        end
                    end else if (to_hit) begin
                        err        <= 1'b1;
                        accum      <= '0;
                        sample_cnt <= '0;
                        abort_q    <= 1'b1;
                        state      <= STORE;
                    end else begin
                        to_cnt <= to_cnt + 10'd1;
                    end
                end
                STORE: begin
                    // the aborted (timeout) path also comes through here so
                    // channel advance and end-of-sweep handling live in one place
                    accum      <= '0;
                    settle_cnt <= '0;
                    if (next_ch[3]) begin
                        cur_ch <= next_ch[2:0];
                        state  <= en ? SETTLE : IDLE;
                    end else begin
                        sweep_done <= 1'b1;
                        if (en && first_ch[3]) begin
                            mask_q <= ch_mask;
                            cur_ch <= first_ch[2:0];
                            state  <= SETTLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // result bank, valid flags and registered read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 8; i++) bank[i] <= '0;
            ch_valid <= '0;
            rd_data  <= '0;
        end else begin
            rd_data <= bank[rd_ch];
            if (state == STORE && !abort_q) begin
                bank[cur_ch]     <= accum[AVG_LOG2 +: 12];
                ch_valid[cur_ch] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_a2d_sequencer.sv
// Directed testbench for a2d_sequencer with a behavioural A2D responder.
module tb_a2d_sequencer;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [7:0]  ch_mask;
    logic        strt_cnv;
    logic [2:0]  chnnl;
    logic        cnv_cmplt;
    logic [11:0] res;
    logic [2:0]  rd_ch;
    logic [11:0] rd_data;
    logic [7:0]  ch_valid;
    logic        sweep_done;
    logic        busy;
    logic        err;
    logic        clr_err;

    int tests;
    int fails;

    // A2D model controls (written only by the main sequence)
    logic       stuck_en;
    logic [2:0] stuck_ch;
    int         res_base;
    int         res_step;
    int         conv_base;

    // monitor / model state (written only by the model process)
    int         req_count;
    int         conv_count;
    int         sd_count;
    int         chnnl_bad;
    int         req_ch  [0:255];
    int         req_w   [0:255];
    int         req_gap [0:255];

    a2d_sequencer #(.AVG_LOG2(2), .SETTLE_CYC(16), .TIMEOUT_CYC(1023)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .ch_mask    (ch_mask),
        .strt_cnv   (strt_cnv),
        .chnnl      (chnnl),
        .cnv_cmplt  (cnv_cmplt),
        .res        (res),
        .rd_ch      (rd_ch),
        .rd_data    (rd_data),
        .ch_valid   (ch_valid),
        .sweep_done (sweep_done),
        .busy       (busy),
        .err        (err),
        .clr_err    (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // A2D responder and request logger, evaluated on the falling edge
    initial begin : a2d_model
        logic       prev_strt;
        logic [2:0] cur_req_ch;
        int         w, gap_cnt, m_phase, m_cnt;
        logic       gap_armed;
        prev_strt = 1'b0; cur_req_ch = '0; w = 0; gap_cnt = 0; gap_armed = 1'b0;
        m_phase = 0; m_cnt = 0;
        req_count = 0; conv_count = 0; sd_count = 0; chnnl_bad = 0;
        cnv_cmplt = 1'b1; res = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_phase = 0; cnv_cmplt = 1'b1; gap_armed = 1'b0; prev_strt = 1'b0;
            end else begin
                if (sweep_done) sd_count++;
                if (strt_cnv && !prev_strt) begin
                    if (req_count < 256) begin
                        req_ch[req_count]  = int'(chnnl);
                        req_gap[req_count] = gap_armed ? gap_cnt : -1;
                        req_w[req_count]   = 0;
                    end
                    cur_req_ch = chnnl;
                    gap_armed  = 1'b0;
                    w = 1;
                    req_count++;
                end else if (strt_cnv) begin
                    w++;
                end else if (prev_strt) begin
                    if (req_count > 0 && req_count <= 256) req_w[req_count-1] = w;
                    if (!(stuck_en && chnnl == stuck_ch)) m_phase = 1;
                end else if (gap_armed) begin
                    gap_cnt++;
                end
                if (m_phase == 1) begin
                    cnv_cmplt = 1'b0; m_cnt = 0; m_phase = 2;
                end else if (m_phase == 2) begin
                    m_cnt++;
                    if (m_cnt == 3) begin
                        res = 12'(res_base + res_step * (conv_count - conv_base));
                        cnv_cmplt = 1'b1;
                        conv_count++;
                        if (chnnl != cur_req_ch) chnnl_bad++;
                        gap_cnt = 0; gap_armed = 1'b1; m_phase = 0;
                    end
                end
                prev_strt = strt_cnv;
            end
        end
    end

    task automatic read_bank(input logic [2:0] ch, output logic [11:0] v);
        rd_ch = ch;
        @(negedge clk);
        @(negedge clk);
        v = rd_data;
    endtask

    task automatic wait_sweep(input int max_cyc, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max_cyc && !found; i++) begin
            @(negedge clk);
            if (sweep_done) found = 1'b1;
        end
        tests++;
        if (!found) begin fails++; $display("FAIL %s: sweep_done got none expected pulse", name); end
    endtask

    task automatic do_reset();
        en = 1'b0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        tests++; if (strt_cnv !== 1'b0) begin fails++; $display("FAIL reset_strt: got %b expected 0", strt_cnv); end
        tests++; if (chnnl !== 3'd0) begin fails++; $display("FAIL reset_chnnl: got %0d expected 0", chnnl); end
        tests++; if (rd_data !== 12'd0) begin fails++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        tests++; if (ch_valid !== 8'h00) begin fails++; $display("FAIL reset_ch_valid: got %0h expected 0", ch_valid); end
        tests++; if ({sweep_done, busy, err} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b expected 000", {sweep_done, busy, err}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_channel();
        int r0, s0;
        logic [11:0] v;
        res_base = 100; res_step = 1; conv_base = conv_count;
        r0 = req_count; s0 = sd_count;
        ch_mask = 8'h01; en = 1'b1;
        wait_sweep(800, "single_sweep");
        en = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (req_count - r0 != 4) begin fails++; $display("FAIL single_req_count: got %0d expected 4", req_count - r0); end
        for (int k = 0; k < 4; k++) begin
            tests++; if (req_ch[r0+k] != 0) begin fails++; $display("FAIL single_ch[%0d]: got %0d expected 0", k, req_ch[r0+k]); end
            tests++; if (req_w[r0+k] != 2) begin fails++; $display("FAIL single_width[%0d]: got %0d expected 2", k, req_w[r0+k]); end
        end
        for (int k = 1; k < 4; k++) begin
            tests++; if (req_gap[r0+k] != 16) begin fails++; $display("FAIL single_gap[%0d]: got %0d expected 16", k, req_gap[r0+k]); end
        end
        tests++; if (ch_valid !== 8'h01) begin fails++; $display("FAIL single_ch_valid: got %0h expected 01", ch_valid); end
        tests++; if (sd_count - s0 != 1) begin fails++; $display("FAIL single_sweep_count: got %0d expected 1", sd_count - s0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy_after: got %b expected 0", busy); end
        tests++; if (chnnl_bad != 0) begin fails++; $display("FAIL single_chnnl_stable: got %0d changes expected 0", chnnl_bad); end
        read_bank(3'd0, v);
        tests++; if (v !== 12'd101) begin fails++; $display("FAIL single_bank0: got %0d expected 101", v); end
    endtask

    task automatic test_mask_a5();
        int r0;
        int e_tab [4] = '{0, 2, 5, 7};
        logic [11:0] v;
        logic found;
        res_base = 12'hFFF; res_step = 0; conv_base = conv_count;
        r0 = req_count;
        ch_mask = 8'hA5; en = 1'b1;
        wait_sweep(2000, "a5_sweep");
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (req_count - r0 >= 17) found = 1'b1;
        end
        en = 1'b0;
        tests++; if (!found) begin fails++; $display("FAIL a5_restart: got no request expected new sweep"); end
        tests++; if (req_ch[r0+16] != 0) begin fails++; $display("FAIL a5_restart_ch: got %0d expected 0", req_ch[r0+16]); end
        for (int k = 0; k < 16; k++) begin
            tests++; if (req_ch[r0+k] != e_tab[k/4]) begin fails++; $display("FAIL a5_order[%0d]: got %0d expected %0d", k, req_ch[r0+k], e_tab[k/4]); end
        end
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (!busy) found = 1'b1;
        end
        tests++; if (!found) begin fails++; $display("FAIL a5_idle: got busy expected idle"); end
        tests++; if (ch_valid !== 8'hA5) begin fails++; $display("FAIL a5_ch_valid: got %0h expected a5", ch_valid); end
        for (int k = 0; k < 4; k++) begin
            read_bank(3'(e_tab[k]), v);
            tests++; if (v !== 12'hFFF) begin fails++; $display("FAIL a5_bank[%0d]: got %0h expected fff", e_tab[k], v); end
        end
        read_bank(3'd1, v);
        tests++; if (v !== 12'd0) begin fails++; $display("FAIL a5_bank1_untouched: got %0h expected 0", v); end
    endtask

    task automatic test_timeout();
        int r0, cnt;
        logic found;
        logic [11:0] v;
        do_reset();
        stuck_en = 1'b1; stuck_ch = 3'd2;
        res_base = 200; res_step = 3; conv_base = conv_count;
        r0 = req_count;
        ch_mask = 8'h0C; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin @(negedge clk); if (strt_cnv) found = 1'b1; end
        for (int i = 0; i < 10 && found; i++) begin @(negedge clk); if (!strt_cnv) found = 1'b0; end
        tests++; if (found) begin fails++; $display("FAIL to_first_request: got no request expected one"); end
        cnt = 0; found = 1'b0;
        for (int i = 0; i < 1200 && !found; i++) begin @(negedge clk); cnt++; if (err) found = 1'b1; end
        tests++; if (cnt != 1023) begin fails++; $display("FAIL to_latency: got %0d clocks expected 1023", cnt); end
        tests++; if (ch_valid[2] !== 1'b0) begin fails++; $display("FAIL to_ch_valid2: got %b expected 0", ch_valid[2]); end
        wait_sweep(800, "to_sweep");
        en = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (ch_valid !== 8'h08) begin fails++; $display("FAIL to_ch_valid: got %0h expected 08", ch_valid); end
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL to_err_sticky: got %b expected 1", err); end
        tests++; if (req_count - r0 != 5) begin fails++; $display("FAIL to_req_count: got %0d expected 5", req_count - r0); end
        tests++; if (req_ch[r0] != 2 || req_ch[r0+1] != 3 || req_ch[r0+4] != 3) begin
            fails++; $display("FAIL to_req_order: got %0d,%0d,%0d expected 2,3,3", req_ch[r0], req_ch[r0+1], req_ch[r0+4]);
        end
        read_bank(3'd2, v);
        tests++; if (v !== 12'd0) begin fails++; $display("FAIL to_bank2: got %0d expected 0", v); end
        read_bank(3'd3, v);
        tests++; if (v !== 12'd204) begin fails++; $display("FAIL to_bank3: got %0d expected 204", v); end
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_clr_err: got %b expected 0", err); end
        stuck_en = 1'b0;
    endtask

    task automatic test_en_drop();
        int c0, s0, r1;
        logic found;
        logic [11:0] v;
        res_base = 300; res_step = 0; conv_base = conv_count;
        ch_mask = 8'h02; en = 1'b1;
        wait_sweep(800, "drop_first_sweep");
        res_base = 500; conv_base = conv_count;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin @(negedge clk); if (strt_cnv) found = 1'b1; end
        for (int i = 0; i < 20 && found; i++) begin @(negedge clk); if (!cnv_cmplt) found = 1'b0; end
        tests++; if (found) begin fails++; $display("FAIL drop_reach_wait: got no conversion expected one"); end
        @(negedge clk);
        en = 1'b0;
        c0 = conv_count; s0 = sd_count;
        @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL drop_busy_held: got %b expected 1", busy); end
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin @(negedge clk); if (!busy) found = 1'b1; end
        tests++; if (!found || conv_count - c0 != 1) begin
            fails++; $display("FAIL drop_finish: got idle=%b conversions=%0d expected idle=1 conversions=1", found, conv_count - c0);
        end
        r1 = req_count;
        repeat (40) @(negedge clk);
        tests++; if (req_count != r1 || busy !== 1'b0) begin fails++; $display("FAIL drop_stays_idle: got %0d new requests busy=%b expected 0 busy=0", req_count - r1, busy); end
        tests++; if (sd_count != s0) begin fails++; $display("FAIL drop_no_sweep_done: got %0d pulses expected 0", sd_count - s0); end
        tests++; if (ch_valid !== 8'h0A) begin fails++; $display("FAIL drop_ch_valid: got %0h expected 0a", ch_valid); end
        read_bank(3'd1, v);
        tests++; if (v !== 12'd300) begin fails++; $display("FAIL drop_bank1: got %0d expected 300", v); end
    endtask

    task automatic test_zero_mask();
        int r0, viol;
        r0 = req_count; viol = 0;
        ch_mask = 8'h00; en = 1'b1;
        repeat (50) begin @(negedge clk); if (busy || strt_cnv) viol++; end
        en = 1'b0;
        tests++; if (viol != 0 || req_count != r0) begin fails++; $display("FAIL zero_mask: got %0d busy clocks %0d requests expected 0 0", viol, req_count - r0); end
    endtask

    task automatic test_read_collision();
        logic found;
        do_reset();
        rd_ch = 3'd0;
        res_base = 40; res_step = 0; conv_base = conv_count;
        ch_mask = 8'h01; en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 800 && !found; i++) begin @(negedge clk); if (sweep_done) found = 1'b1; end
        tests++; if (!found) begin fails++; $display("FAIL coll_sweep: got none expected pulse"); end
        tests++; if (rd_data !== 12'd0) begin fails++; $display("FAIL coll_old_value: got %0d expected 0", rd_data); end
        @(negedge clk);
        tests++; if (rd_data !== 12'd40) begin fails++; $display("FAIL coll_new_value: got %0d expected 40", rd_data); end
        tests++; if (ch_valid !== 8'h01) begin fails++; $display("FAIL coll_ch_valid: got %0h expected 01", ch_valid); end
    endtask

    task automatic test_async_reset();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin @(negedge clk); if (!cnv_cmplt) found = 1'b1; end
        @(negedge clk);
        tests++; if (!found || busy !== 1'b1) begin fails++; $display("FAIL areset_setup: got waiting=%b busy=%b expected 1 1", found, busy); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if ({strt_cnv, busy, sweep_done, err} !== 4'b0000) begin fails++; $display("FAIL areset_flags: got %b expected 0000", {strt_cnv, busy, sweep_done, err}); end
        tests++; if (chnnl !== 3'd0 || ch_valid !== 8'h00) begin fails++; $display("FAIL areset_ch: got chnnl=%0d ch_valid=%0h expected 0 0", chnnl, ch_valid); end
        tests++; if (rd_data !== 12'd0) begin fails++; $display("FAIL areset_rd_data: got %0d expected 0", rd_data); end
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin : main
        rst_n = 1'b0; en = 1'b0; ch_mask = '0; rd_ch = '0; clr_err = 1'b0;
        stuck_en = 1'b0; stuck_ch = '0; res_base = 0; res_step = 0; conv_base = 0;
        tests = 0; fails = 0;
        test_reset();
        test_single_channel();
        test_mask_a5();
        test_timeout();
        test_en_drop();
        test_zero_mask();
        test_read_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/a2d_sequencer.md
Name: a2d_sequencer

Overview:
- Upstream controller for the SPI A2D interface block.
- Round-robins over the 8 analog channels and requests one conversion at a time via strt_cnv/chnnl, then waits for cnv_cmplt.
- Accumulates 2^AVG_LOG2 results per channel, truncates to a 12-bit average and stores it in a per-channel result bank.
- The bank is readable through a registered read port by downstream control logic.

Parameters:
- AVG_LOG2, 2, log2 of samples averaged per channel (4 samples); legal 0..4.
- SETTLE_CYC, 16, idle clocks between consecutive conversion requests; legal 1..255.
- TIMEOUT_CYC, 1023, max clocks waited in either wait state before abort; legal 16..1023.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- en  in  1  level: run sweeps continuously while high
- ch_mask  in  8  bit i=1 includes channel i in the sweep; sampled at sweep start
- strt_cnv  out  1  conversion request to A2D interface
- chnnl  out  3  channel being converted; stable from strt_cnv rise until cnv_cmplt returns high
- cnv_cmplt  in  1  A2D done/idle flag (high = idle)
- res  in  12  A2D result; valid while cnv_cmplt high after conversion
- rd_ch  in  3  read channel select
- rd_data  out  12  average of rd_ch, registered (1-clock latency)
- ch_valid  out  8  bit i set once channel i has a stored average
- sweep_done  out  1  1-clock pulse after last enabled channel of a sweep is stored
- busy  out  1  high in any state except IDLE
- err  out  1  sticky timeout flag
- clr_err  in  1  synchronous clear of err; a simultaneous new timeout wins

Behaviour:
- Reset values: strt_cnv=0, chnnl=0, rd_data=0, ch_valid=0, sweep_done=0, busy=0, err=0; all bank entries=0; accumulator=0; state=IDLE.
- State machine states: IDLE, SETTLE, START, WAIT_BUSY, WAIT_DONE, STORE.
- IDLE:
  - If en=1 and ch_mask!=0: latch ch_mask into mask_q, select the lowest set bit as current channel, go to SETTLE.
  - If ch_mask==0: stay in IDLE.
- SETTLE: count SETTLE_CYC clocks, then go to START.
- START:
  - Drive strt_cnv=1 for exactly 2 consecutive clocks; the A2D filters the request with two flops, so 1 clock is insufficient.
  - chnnl is driven with the current channel from the first START clock onward.
  - Then go to WAIT_BUSY.
- WAIT_BUSY:
  - Wait for cnv_cmplt=0.
  - If cnv_cmplt was already 0 on entry, accept it immediately.
  - Go to WAIT_DONE.
- WAIT_DONE:
  - Wait for cnv_cmplt=1.
  - On the same clock: accum += res (zero-extended to 12+AVG_LOG2 bits) and sample_cnt++.
  - If sample_cnt wraps to 0 (2^AVG_LOG2 samples taken), go to STORE; otherwise go to SETTLE for the same channel.
- STORE:
  - bank[ch] <= accum[11+AVG_LOG2:AVG_LOG2] (truncating, no rounding); ch_valid[ch] <= 1; clear accum.
  - Advance to the next higher set bit in mask_q.
  - If none remain, pulse sweep_done: next state is SETTLE with a fresh mask if en=1, else IDLE.
- Timeout:
  - Counter resets on entry to WAIT_BUSY and WAIT_DONE and runs while in either state.
  - On reaching TIMEOUT_CYC: set err, discard accum and sample_cnt for the channel (bank not updated), advance the channel as in STORE. sweep_done still pulses at end of sweep.
- en falling mid-sweep:
  - The current conversion completes (WAIT states are not abandoned).
  - Then discard the partial accumulation and go to IDLE without storing or pulsing sweep_done.
  - If en falls during SETTLE or IDLE-exit, go to IDLE immediately.
- ch_mask changes mid-sweep are ignored until the next sweep start.
- Read port: rd_data <= bank[rd_ch] every clock.
  - A read of a channel being stored in the same clock returns the old value; the new value appears 1 clock later.
- busy = (state != IDLE).
- Asynchronous reset mid-conversion returns everything to reset values at once. The A2D's own reset is the same rst_n, so no handshake recovery is needed.

Test Plan:
- Reset, en=1, ch_mask=8'h01, A2D model returns 100,101,102,103 -> strt_cnv high exactly 2 clocks per request with chnnl=0, SETTLE_CYC=16 gap between requests; after 4 conversions bank[0]=101 (406>>2), ch_valid=8'h01, sweep_done pulses once.
- ch_mask=8'hA5, res=12'hFFF always -> channels requested in order 0,2,5,7 only; each bank entry=12'hFFF (no overflow in 14-bit accum); sweep_done after channel 7; next sweep restarts at channel 0.
- A2D model never lowers cnv_cmplt on channel 2, ch_mask=8'h0C -> err=1 after 1023 clocks in WAIT_BUSY, bank[2] unchanged and ch_valid[2]=0, channel 3 then converts normally; clr_err=1 clears err.
- Drop en during channel 1's WAIT_DONE -> conversion finishes, no store, no sweep_done, busy falls, state IDLE; bank[1] keeps its previous value.
- ch_mask=0 with en=1 -> strt_cnv never asserts, busy=0.
- rd_ch=0 with a STORE to channel 0 in the same clock -> rd_data shows old value that clock and new value the next clock; assert rst_n=0 mid-WAIT_DONE -> all outputs return to reset values asynchronously.
